// File: rtl/eth_tx_clk_rst_gen.sv
// eth_tx_clk_rst_gen: gtx and quarter-period-shifted RGMII PHY TX clocks with glitch-free speed switching
//   clk_i/reset_i        : reference clock, async active-high reset
//   speed_i              : requested speed (00 1G, 01 100M, 10 10M, 11 ignored), async
//   gtx_clk_r_o          : registered MAC-side TX clock
//   phy_tx_clk_oddr_r_o  : ODDR pair, [0] rising half, [1] falling half of each clk_i cycle
//   gtx_rst_r_o          : gtx-domain reset, active-high
//   speed_r_o / ready_o  : speed in effect / clocks running with reset released
module eth_tx_clk_rst_gen #(
  parameter int half_period_1g_p   = 1,
  parameter int half_period_100m_p = 5,
  parameter int half_period_10m_p  = 50,
  parameter int hold_cycles_p      = 8,
  parameter int sync_stages_p      = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] speed_i,
  output logic       gtx_clk_r_o,
  output logic [1:0] phy_tx_clk_oddr_r_o,
  output logic       gtx_rst_r_o,
  output logic [1:0] speed_r_o,
  output logic       ready_o
);
  localparam int h12_lp = half_period_1g_p > half_period_100m_p ? half_period_1g_p : half_period_100m_p;
  localparam int hmax_lp = h12_lp > half_period_10m_p ? h12_lp : half_period_10m_p;
  localparam int cw_lp = $clog2(2 * hmax_lp + 1);
  localparam int hw_lp = $clog2(hold_cycles_p + 1);
  localparam logic [1:0] HOLD = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [sync_stages_p-1:0][1:0] r_sync;
  logic [1:0] r_state, w_state_n, r_p, w_p_n, w_speed_n, w_speed_s, w_phy_n;
  logic [hw_lp-1:0] r_hold, w_hold_n;
  logic [cw_lp-1:0] r_cnt, w_cnt_n, w_h;
  logic [cw_lp:0] w_s0, w_s1, w_h1, w_h3;
  logic w_req, w_last, w_rst_n, w_run_n, w_gtx_n;
  assign w_speed_s = r_sync[sync_stages_p-1];
  assign w_h = speed_r_o == 2'b01 ? cw_lp'(half_period_100m_p) :
               speed_r_o == 2'b10 ? cw_lp'(half_period_10m_p) : cw_lp'(half_period_1g_p);
  assign w_req = w_speed_s != 2'b11 && w_speed_s != speed_r_o;
  assign w_last = r_cnt == (w_h << 1) - cw_lp'(1);
  assign ready_o = r_state != HOLD && !gtx_rst_r_o;
  always_comb begin
    w_state_n = r_state;
    w_hold_n = '0;
    w_cnt_n = w_last ? '0 : r_cnt + cw_lp'(1);
    w_p_n = w_last && r_p != 2'd2 ? r_p + 2'd1 : r_p;
    w_speed_n = speed_r_o;
    w_rst_n = gtx_rst_r_o;
    if (r_state == HOLD) begin
      w_cnt_n = '0;
      w_p_n = '0;
      w_rst_n = 1'b1;
      if (w_req) w_speed_n = w_speed_s;
      else if (r_hold == hw_lp'(hold_cycles_p - 1)) w_state_n = RUN;
      else w_hold_n = r_hold + hw_lp'(1);
    end else if (r_state == RUN) begin
      w_state_n = w_req ? DRAIN : RUN;
      // release on the edge where cnt becomes H in period 1: a gtx falling edge after two rising edges
      w_rst_n = gtx_rst_r_o && !(r_p == 2'd1 && r_cnt == w_h - cw_lp'(1));
    end else if (w_last) begin
      w_state_n = HOLD;
      w_cnt_n = '0;
      w_p_n = '0;
      w_rst_n = 1'b1;
    end
    // outputs are registered from the next count so they line up with r_cnt in the same cycle
    w_run_n = w_state_n != HOLD;
    w_s0 = {w_cnt_n, 1'b0};
    w_s1 = {w_cnt_n, 1'b1};
    w_h1 = {1'b0, w_h};
    w_h3 = w_h1 + (w_h1 << 1);
    w_gtx_n = w_run_n && w_cnt_n < w_h;
    w_phy_n = {w_run_n && w_s1 >= w_h1 && w_s1 < w_h3, w_run_n && w_s0 >= w_h1 && w_s0 < w_h3};
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= '0;
      r_state <= HOLD;
      r_hold <= '0;
      r_cnt <= '0;
      r_p <= '0;
      gtx_clk_r_o <= 1'b0;
      phy_tx_clk_oddr_r_o <= 2'b00;
      gtx_rst_r_o <= 1'b1;
      speed_r_o <= 2'b00;
    end else begin
      r_sync[0] <= speed_i;
      for (int i = 1; i < sync_stages_p; i++) r_sync[i] <= r_sync[i-1];
      r_state <= w_state_n;
      r_hold <= w_hold_n;
      r_cnt <= w_cnt_n;
      r_p <= w_p_n;
      gtx_clk_r_o <= w_gtx_n;
      phy_tx_clk_oddr_r_o <= w_phy_n;
      gtx_rst_r_o <= w_rst_n;
      speed_r_o <= w_speed_n;
    end
  end
endmodule

// File: tb/tb_eth_tx_clk_rst_gen.sv
// tb_eth_tx_clk_rst_gen: scoreboard and pulse-width bench for eth_tx_clk_rst_gen
module tb_eth_tx_clk_rst_gen;
  logic clk = 1'b0, reset_i = 1'b1;
  logic [1:0] speed_i = 2'b00;
  logic gtx_clk_r_o, gtx_rst_r_o, ready_o;
  logic [1:0] phy_tx_clk_oddr_r_o, speed_r_o;
  logic [6:0] exp_q[$];
  int checks = 0, failures = 0;
  bit glitch_en = 0;
  int bound_h, slot, g_run, p_run, g_edges, p_edges, g_rise, p_rise, pulses;
  logic g_lvl, p_lvl;
  always #5 clk = ~clk;
  eth_tx_clk_rst_gen dut (
    .clk_i(clk), .reset_i(reset_i), .speed_i(speed_i), .gtx_clk_r_o(gtx_clk_r_o),
    .phy_tx_clk_oddr_r_o(phy_tx_clk_oddr_r_o), .gtx_rst_r_o(gtx_rst_r_o),
    .speed_r_o(speed_r_o), .ready_o(ready_o)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_ge(string tag, int obs, int lim);
    checks++;
    assert (obs >= lim) else begin
      failures++;
      $error("FAIL %s observed=%0d expected>=%0d", tag, obs, lim);
    end
  endtask
  function automatic int hof(logic [1:0] v);
    return v == 2'b01 ? 5 : v == 2'b10 ? 50 : 1;
  endfunction
  task automatic push_hold(int n, logic [1:0] spd);
    repeat (n) exp_q.push_back({1'b0, 2'b00, 1'b1, spd, 1'b0});
  endtask
  task automatic push_run(int h, logic [1:0] spd, int p0, int np);
    logic rel;
    logic [1:0] ph;
    for (int p = p0; p < p0 + np; p++)
      for (int c = 0; c < 2 * h; c++) begin
        rel = p >= 2 || (p == 1 && c >= h);
        for (int b = 0; b < 2; b++) ph[b] = (2 * c + b >= h) && (2 * c + b < 3 * h);
        exp_q.push_back({c < h, ph, !rel, spd, rel});
      end
  endtask
  task automatic drain_q;
    for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      chk("sb_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask
  task automatic chk_reset;
    chk("rst_gtx", gtx_clk_r_o, 0);
    chk("rst_phy", phy_tx_clk_oddr_r_o, 0);
    chk("rst_rst", gtx_rst_r_o, 1);
    chk("rst_spd", speed_r_o, 0);
    chk("rst_rdy", ready_o, 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0)
      chk("sb", {gtx_clk_r_o, phy_tx_clk_oddr_r_o, gtx_rst_r_o, speed_r_o, ready_o}, exp_q.pop_front());
  end
  initial forever begin
    @(negedge clk);
    if (glitch_en) begin
      for (int b = 0; b < 2; b++) begin
        if (phy_tx_clk_oddr_r_o[b] !== p_lvl) begin
          if (p_edges >= 2) chk_ge("phy_pulse", p_run, 2 * bound_h);
          if (phy_tx_clk_oddr_r_o[b]) p_rise = slot + b;
          p_edges++;
          p_lvl = phy_tx_clk_oddr_r_o[b];
          p_run = 0;
        end
        p_run++;
      end
      if (gtx_clk_r_o !== g_lvl) begin
        if (g_edges >= 2) chk_ge("gtx_pulse", g_run, bound_h);
        if (gtx_clk_r_o) g_rise = g_edges >= 1 ? slot : -1;
        else if (g_rise >= 0) chk("phy_lag", p_rise - g_rise, (slot - g_rise) / 2);
        g_edges++;
        g_lvl = gtx_clk_r_o;
        g_run = 0;
        pulses++;
      end
      g_run++;
      slot += 2;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] v, last;
    int cur_h;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    reset_i = 1'b0;
    push_hold(8, 2'b00);
    push_run(1, 2'b00, 0, 4);
    drain_q();
    speed_i = 2'b10;
    push_run(1, 2'b00, 2, 2);
    push_hold(1, 2'b00);
    push_hold(8, 2'b10);
    push_run(50, 2'b10, 0, 3);
    drain_q();
    chk("hi_before_reset", gtx_clk_r_o, 1);
    reset_i = 1'b1;
    speed_i = 2'b01;
    #1;
    chk_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    push_hold(3, 2'b00);
    push_hold(8, 2'b01);
    push_run(5, 2'b01, 0, 3);
    drain_q();
    speed_i = 2'b11;
    push_run(5, 2'b01, 2, 4);
    drain_q();
    speed_i = 2'b01;
    g_edges = 0; p_edges = 0; g_rise = -1; p_rise = 0; slot = 0; g_run = 0; p_run = 0; pulses = 0;
    g_lvl = 1'bx; p_lvl = 1'bx;
    cur_h = 5; bound_h = 5; last = 2'b01;
    glitch_en = 1;
    for (int k = 0; k < 12; k++) begin
      v = 2'($urandom_range(0, 3));
      speed_i = v;
      if (v != 2'b11) begin
        bound_h = cur_h < hof(v) ? cur_h : hof(v);
        cur_h = hof(v);
        last = v;
      end
      repeat ($urandom_range(350, 450)) @(posedge clk);
    end
    #1;
    glitch_en = 0;
    chk("final_spd", speed_r_o, last);
    chk("final_rdy", ready_o, 1);
    chk_ge("pulses", pulses, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
